// File: rtl/trace_debugger_sample_buffer.sv
// ============================================================================
// Module   : trace_debugger_sample_buffer
// Brief    : Non-stalling elastic buffer for per-cycle instruction trace samples
//            with drop counting and a resync tag on the first sample after a loss.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_debugger_sample_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     ivalid_i,
    input  logic                     iexception_i,
    input  logic                     interrupt_i,
    input  logic [4:0]               cause_i,
    input  logic [31:0]              tval_i,
    input  logic [2:0]               priv_i,
    input  logic [31:0]              iaddr_i,
    input  logic [31:0]              instr_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     iexception_o,
    output logic                     interrupt_o,
    output logic [4:0]               cause_o,
    output logic [31:0]              tval_o,
    output logic [2:0]               priv_o,
    output logic [31:0]              iaddr_o,
    output logic [31:0]              instr_o,
    output logic                     lost_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int SW = 1 + 1 + 5 + 32 + 3 + 32 + 32 + 1;

    localparam logic [FW-1:0]    c_full    = FW'(DEPTH);
    localparam logic [FW-1:0]    c_fill_one = FW'(1);
    localparam logic [AW-1:0]    c_ptr_one = AW'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [SW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [FW-1:0]    r_fill;
    logic [FW-1:0]    w_fill_nxt;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_lost_pend;

    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_accept;
    logic             w_drop;
    logic [SW-1:0]    w_wdata;
    logic [SW-1:0]    w_head;

    assign w_valid  = (r_fill != '0);
    assign w_full   = (r_fill == c_full);
    assign w_push   = ivalid_i & enable_i & ~clear_i;
    assign w_pop    = w_valid & ready_i & ~clear_i;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    assign w_wdata = {iexception_i, interrupt_i, cause_i, tval_i, priv_i,
                      iaddr_i, instr_i, r_lost_pend};

    always_comb begin
        w_fill_nxt = r_fill;
        case ({w_accept, w_pop})
            2'b10:   w_fill_nxt = r_fill + c_fill_one;
            2'b01:   w_fill_nxt = r_fill - c_fill_one;
            default: w_fill_nxt = r_fill;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
            r_lost_pend <= 1'b0;
        end else if (clear_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
            r_lost_pend <= 1'b0;
        end else begin
            r_fill <= w_fill_nxt;
            if (w_accept) begin
                r_wr_ptr    <= r_wr_ptr + c_ptr_one;
                r_lost_pend <= 1'b0;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_drop) begin
                r_overflow  <= 1'b1;
                r_lost_pend <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + c_cnt_one;
                end
            end
        end
    end

    // Head fields read as zero while empty so stale storage never leaks out.
    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign {iexception_o, interrupt_o, cause_o, tval_o, priv_o,
            iaddr_o, instr_o, lost_o} = w_head;

    assign valid_o    = w_valid;
    assign fill_o     = r_fill;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trace_debugger_sample_buffer.sv
// ============================================================================
// Module   : tb_trace_debugger_sample_buffer
// Brief    : Queue-model bench for trace_debugger_sample_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_debugger_sample_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic        iexc;
        logic        intr;
        logic [4:0]  cause;
        logic [31:0] tval;
        logic [2:0]  priv;
        logic [31:0] iaddr;
        logic [31:0] instr;
        logic        lost;
    } sample_t;

    logic clk, rst_n, enable, clear, ivalid, iexc, intr, ready;
    logic [4:0]  cause;
    logic [31:0] tval, iaddr, instr;
    logic [2:0]  priv;
    logic        valid_o, iexc_o, intr_o, lost_o, overflow_o;
    logic [4:0]  cause_o;
    logic [31:0] tval_o, iaddr_o, instr_o;
    logic [2:0]  priv_o;
    logic [CNT_W-1:0] drop_cnt_o;
    logic [3:0]  fill_o;

    trace_debugger_sample_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
        .ivalid_i(ivalid), .iexception_i(iexc), .interrupt_i(intr),
        .cause_i(cause), .tval_i(tval), .priv_i(priv), .iaddr_i(iaddr),
        .instr_i(instr), .valid_o(valid_o), .ready_i(ready),
        .iexception_o(iexc_o), .interrupt_o(intr_o), .cause_o(cause_o),
        .tval_o(tval_o), .priv_o(priv_o), .iaddr_o(iaddr_o),
        .instr_o(instr_o), .lost_o(lost_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o), .fill_o(fill_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    sample_t          q[$];
    bit               m_ovf   = 0;
    int unsigned      m_drops = 0;
    bit               m_lostp = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is just a bounded FIFO; a pop frees room before the push.
    always @(posedge clk or negedge rst_n) begin : model
        sample_t s;
        bit      do_push, do_pop;
        if (!rst_n) begin
            q.delete();
            m_ovf = 0; m_drops = 0; m_lostp = 0;
        end else begin
            do_push = ivalid && enable && !clear;
            do_pop  = (q.size() > 0) && ready && !clear;
            if (clear) begin
                q.delete();
                m_ovf = 0; m_drops = 0; m_lostp = 0;
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    if (q.size() < DEPTH) begin
                        s = '{iexc, intr, cause, tval, priv, iaddr, instr, m_lostp};
                        q.push_back(s);
                        m_lostp = 0;
                    end else begin
                        m_ovf = 1;
                        if (m_drops != (1 << CNT_W) - 1) m_drops++;
                        m_lostp = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        sample_t act, exp;
        act = '{iexc_o, intr_o, cause_o, tval_o, priv_o, iaddr_o, instr_o, lost_o};
        exp = (q.size() > 0) ? q[0] : '0;
        check("valid", 128'(valid_o), 128'(q.size() != 0));
        check("fill", 128'(fill_o), 128'(q.size()));
        check("overflow", 128'(overflow_o), 128'(m_ovf));
        check("drop_cnt", 128'(drop_cnt_o), 128'(m_drops));
        check("head", 128'(act), 128'(exp));
    end

    task automatic set_sample(input logic [31:0] a);
        iaddr = a;
        instr = a ^ 32'hA5A5_0000;
        tval  = ~a;
        cause = a[6:2];
        priv  = a[4:2];
        iexc  = a[2];
        intr  = a[3];
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; ivalid = 1'b0; ready = 1'b0;
        set_sample(32'h0);
        tick(3);
        check("reset_valid", 128'(valid_o), 128'(0));
        check("reset_fill", 128'(fill_o), 128'(0));
        rst_n = 1'b1;
        tick(1);

        // 1: fill to capacity, head held
        for (int i = 0; i < 8; i++) begin
            ivalid = 1'b1; set_sample(32'h100 + 32'(4 * i)); tick(1);
        end
        ivalid = 1'b0; set_sample(32'hDEAD_BEEF); tick(2);
        check("t1_fill", 128'(fill_o), 128'(8));
        check("t1_valid", 128'(valid_o), 128'(1));
        check("t1_head", 128'(iaddr_o), 128'(32'h100));

        // 2: overflow drop, then resync tag on next stored sample
        ivalid = 1'b1; set_sample(32'h120); tick(1);
        ivalid = 1'b0;
        check("t2_drop", 128'(drop_cnt_o), 128'(1));
        check("t2_ovf", 128'(overflow_o), 128'(1));
        ready = 1'b1; tick(1); ready = 1'b0;
        ivalid = 1'b1; set_sample(32'h124); tick(1);

        // 3: simultaneous push+pop while full
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_sample(32'h128 + 32'(4 * i)); tick(1);
        end
        ivalid = 1'b0; ready = 1'b0;
        check("t3_fill", 128'(fill_o), 128'(8));
        check("t3_drop", 128'(drop_cnt_o), 128'(1));
        check("t3_head", 128'(iaddr_o), 128'(32'h114));
        ready = 1'b1; tick(3);
        check("t2_lost_addr", 128'(iaddr_o), 128'(32'h124));
        check("t2_lost_flag", 128'(lost_o), 128'(1));
        tick(1);
        check("t2_after_lost", 128'(lost_o), 128'(0));
        tick(4);
        check("t3_drained", 128'(fill_o), 128'(0));
        ready = 1'b0;
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clr_ovf", 128'(overflow_o), 128'(0));
        check("clr_drop", 128'(drop_cnt_o), 128'(0));

        // 4: streaming with ready toggling across pointer wrap
        for (int i = 0; i < 20; i++) begin
            ivalid = 1'b1; ready = i[0]; set_sample(32'h200 + 32'(4 * i)); tick(1);
        end
        ivalid = 1'b0; ready = 1'b1; tick(10);
        check("t4_drained", 128'(fill_o), 128'(0));
        ready = 1'b0; clear = 1'b1; tick(1); clear = 1'b0;

        // 5: idle / disabled input, clear wins over push
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b0; set_sample(32'h300 + 32'(4 * i)); tick(1);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b1; set_sample(32'h310 + 32'(4 * i)); tick(1);
        end
        check("t5_fill", 128'(fill_o), 128'(0));
        check("t5_drop", 128'(drop_cnt_o), 128'(0));
        enable = 1'b1; set_sample(32'h320); tick(1);
        check("t5_one", 128'(fill_o), 128'(1));
        clear = 1'b1; set_sample(32'h324); tick(1);
        clear = 1'b0; ivalid = 1'b0;
        check("t5_clear", 128'(fill_o), 128'(0));

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 9; i++) begin
            ivalid = 1'b1; set_sample(32'h400 + 32'(4 * i)); tick(1);
        end
        ivalid = 1'b0; ready = 1'b1; tick(3); ready = 1'b0;
        check("t6_pre_fill", 128'(fill_o), 128'(5));
        check("t6_pre_ovf", 128'(overflow_o), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 128'(valid_o), 128'(0));
        check("t6_rst_fill", 128'(fill_o), 128'(0));
        check("t6_rst_ovf", 128'(overflow_o), 128'(0));
        check("t6_rst_addr", 128'(iaddr_o), 128'(0));
        tick(2);
        rst_n = 1'b1;
        ivalid = 1'b1; set_sample(32'h500); tick(1);
        ivalid = 1'b0;
        check("t6_post_valid", 128'(valid_o), 128'(1));
        check("t6_post_addr", 128'(iaddr_o), 128'(32'h500));
        check("t6_post_lost", 128'(lost_o), 128'(0));
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
